module_teclado: RTL and testbench

Matrix keypad scanner for the 4x4 keypad. It drives one column low at a time and samples the active-low rows through a two-flop synchronizer. A detected key is debounced on press and on release. The block presents the key's column and row codes with an active-low valid strobe `dato_listo_o`. Its outputs connect directly to the capture subsystem's `dato_codc_i`, `dato_codf_i` and `dato_listo_i`, which sample the codes while the strobe is low.

---
 rtl/module_teclado_if.sv | 25 ++
 rtl/module_teclado.sv | 168 ++++++++++++++++
 tb/tb_module_teclado.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/module_teclado_if.sv
// Keypad-side and capture-side signals of the 4x4 matrix keypad scanner.
// The scanner uses the master modport. The keypad/consumer side uses the slave modport.
interface module_teclado_if;
    logic [3:0] filas_i;       // keypad rows, asynchronous, active-low
    logic [3:0] columnas_o;    // one-hot active-low column drive
    logic [1:0] dato_codc_o;   // column code of the accepted key
    logic [1:0] dato_codf_o;   // row code of the accepted key
    logic       dato_listo_o;  // active-low valid, low while the key is held

    modport master (
        input  filas_i,
        output columnas_o,
        output dato_codc_o,
        output dato_codf_o,
        output dato_listo_o
    );

    modport slave (
        output filas_i,
        input  columnas_o,
        input  dato_codc_o,
        input  dato_codf_o,
        input  dato_listo_o
    );
endinterface

// File: rtl/module_teclado.sv
// 4x4 matrix keypad scanner with press/release debounce.
// The block drives one column low at a time and samples the synchronised rows at the end of
// each slot. It then debounces the first key it finds. While an accepted key is held, it
// presents the column and row codes with an active-low strobe.
module module_teclado #(
    parameter int SCAN_DIV        = 27000,   // cycles per column slot (>= 4)
    parameter int DEBOUNCE_CYCLES = 270000   // stable cycles to accept press/release (>= 2)
) (
    input  logic             clk,
    input  logic             rst,            // synchronous, active-low
    module_teclado_if.master bus
);
    localparam int SLOT_W = $clog2(SCAN_DIV);
    localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES);

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] BARRIDO   = 2'd0;
    localparam logic [1:0] REBOTE_P  = 2'd1;
    localparam logic [1:0] SOSTENIDO = 2'd2;
    localparam logic [1:0] REBOTE_S  = 2'd3;

    logic [3:0]        filas_m;
    logic [3:0]        filas_s;
    logic              hit;
    logic [1:0]        fila_enc;
    logic              fila_baja;
    logic              presion_ok;

    logic [1:0]        estado;
    logic [1:0]        col_idx;
    logic [1:0]        col_next;
    logic [1:0]        col_q;
    logic [1:0]        col_q_next;
    logic [1:0]        fila_q;
    logic [SLOT_W-1:0] slot_cnt;
    logic [DEB_W-1:0]  deb_cnt;

    logic [3:0]        columnas;
    logic [1:0]        codc;
    logic [1:0]        codf;
    logic              listo;

    // Column drive pattern for a column index: only that bit is low.
    function automatic logic [3:0] col_drive(input logic [1:0] idx);
        logic [3:0] v;
        v      = 4'b1111;
        v[idx] = 1'b0;
        return v;
    endfunction

    // Two-flop synchroniser for the asynchronous row inputs; idle level is all ones.
    always_ff @(posedge clk) begin
        // NOTE: flops take non-blocking assignments so every register samples pre-edge values.
        if (!rst) begin
            filas_m <= 4'b1111;
            filas_s <= 4'b1111;
        end else begin
            filas_m <= bus.filas_i;
            filas_s <= filas_m;
        end
    end

    // Row detection: any low row is a hit, and the lowest-numbered low row wins.
    always_comb begin
        // NOTE: every output gets a default first, so no path leaves a value held (no latch).
        hit        = ~&filas_s;
        fila_enc   = 2'd0;
        if (!filas_s[0])      fila_enc = 2'd0;
        else if (!filas_s[1]) fila_enc = 2'd1;
        else if (!filas_s[2]) fila_enc = 2'd2;
        else if (!filas_s[3]) fila_enc = 2'd3;
        fila_baja  = ~filas_s[fila_q];
        presion_ok = fila_baja && (fila_enc == fila_q);
        col_next   = col_idx + 2'd1;
        col_q_next = col_q + 2'd1;
    end

    // Scan / debounce state machine with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            estado   <= BARRIDO;
            col_idx  <= 2'd0;
            col_q    <= 2'd0;
            fila_q   <= 2'd0;
            slot_cnt <= '0;
            deb_cnt  <= '0;
            columnas <= 4'b1110;
            codc     <= 2'd0;
            codf     <= 2'd0;
            listo    <= 1'b1;
        end else begin
            case (estado)
                BARRIDO: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt <= '0;
                        if (hit) begin
                            // Freeze on this column and start the press debounce.
                            col_q   <= col_idx;
                            fila_q  <= fila_enc;
                            deb_cnt <= '0;
                            estado  <= REBOTE_P;
                        end else begin
                            col_idx  <= col_next;
                            columnas <= col_drive(col_next);
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end

                REBOTE_P: begin
                    if (presion_ok) begin
                        if (deb_cnt == DEB_LAST) begin
                            codc    <= col_q;
                            codf    <= fila_q;
                            listo   <= 1'b0;
                            deb_cnt <= '0;
                            estado  <= SOSTENIDO;
                        end else begin
                            deb_cnt <= deb_cnt + 1'b1;
                        end
                    end else begin
                        // Press did not hold: resume the scan on the next column.
                        slot_cnt <= '0;
                        deb_cnt  <= '0;
                        col_idx  <= col_q_next;
                        columnas <= col_drive(col_q_next);
                        estado   <= BARRIDO;
                    end
                end

                SOSTENIDO: begin
                    // Only the accepted row is watched; other keys are ignored.
                    if (!fila_baja) begin
                        deb_cnt <= '0;
                        estado  <= REBOTE_S;
                    end
                end

                REBOTE_S: begin
                    if (fila_baja) begin
                        // A bounce back low restarts the release count without a new strobe.
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        listo    <= 1'b1;
                        deb_cnt  <= '0;
                        slot_cnt <= '0;
                        col_idx  <= col_q_next;
                        columnas <= col_drive(col_q_next);
                        estado   <= BARRIDO;
                    end else begin
                        deb_cnt <= deb_cnt + 1'b1;
                    end
                end

                default: estado <= BARRIDO;
            endcase
        end
    end

    assign bus.columnas_o   = columnas;
    assign bus.dato_codc_o  = codc;
    assign bus.dato_codf_o  = codf;
    assign bus.dato_listo_o = listo;

endmodule

// File: tb/tb_module_teclado.sv
// Bench for the 4x4 keypad scanner. A keypad model pulls a row low while that key is pressed
// and its column is driven. Expected codes, latency bounds and resume columns come from the
// keypad rules.
module tb_module_teclado;
    localparam int SCAN_DIV = 4;
    localparam int DEB      = 8;
    localparam int LAT_MAX  = 4 * SCAN_DIV + 2 + DEB + 1;   // 27
    localparam int LAT_MIN  = 2 + DEB + 1;                  // 11
    localparam int REL_LAT  = 2 + DEB + 1;                  // 11

    logic clk = 1'b0;
    logic rst = 1'b0;

    module_teclado_if bus ();

    module_teclado #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Keypad model: key bit index = col*4 + row.
    logic [15:0] keys = '0;
    logic [3:0]  row_model;

    always_comb begin
        row_model = 4'b1111;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && bus.columnas_o[c] === 1'b0) row_model[r] = 1'b0;
    end
    assign bus.filas_i = row_model;

    int total   = 0;
    int bad     = 0;
    int strobes = 0;
    logic       prev_listo = 1'b1;
    logic [3:0] held_codes = 4'd0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    function automatic int kbit(input int c, input int r);
        return c * 4 + r;
    endfunction

    function automatic int col_pat(input int c);
        logic [3:0] v;
        v    = 4'b1111;
        v[c] = 1'b0;
        return int'(v);
    endfunction

    // Strobe counter and code-stability monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (prev_listo === 1'b1 && bus.dato_listo_o === 1'b0) begin
            strobes    <= strobes + 1;
            held_codes <= {bus.dato_codc_o, bus.dato_codf_o};
        end
        if (prev_listo === 1'b0 && bus.dato_listo_o === 1'b0)
            check("code_hold", int'({bus.dato_codc_o, bus.dato_codf_o}), int'(held_codes));
        prev_listo <= bus.dato_listo_o;
    end

    // Waits for dato_listo_o to reach lvl. Returns negedges elapsed, or -1 on timeout.
    task automatic wait_listo(input logic lvl, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.dato_listo_o !== lvl && n < budget);
        if (bus.dato_listo_o !== lvl) n = -1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_cols"},  int'(bus.columnas_o), 4'b1110);
        check({tag, "_codc"},  int'(bus.dato_codc_o), 0);
        check({tag, "_codf"},  int'(bus.dato_codf_o), 0);
        check({tag, "_listo"}, int'(bus.dato_listo_o), 1);
    endtask

    task automatic press_expect(input string tag, input logic [15:0] k,
                                input int codc, input int codf, input int lo, input int hi);
        int n;
        keys = k;
        wait_listo(1'b0, hi + 5, n);
        check_range({tag, "_press_lat"}, n, lo, hi);
        check({tag, "_codc"}, int'(bus.dato_codc_o), codc);
        check({tag, "_codf"}, int'(bus.dato_codf_o), codf);
        check({tag, "_cols_held"}, int'(bus.columnas_o), col_pat(codc));
    endtask

    task automatic release_expect(input string tag, input int codc, input int codf,
                                  input int lo, input int hi);
        int n;
        keys = '0;
        wait_listo(1'b1, hi + 5, n);
        check_range({tag, "_rel_lat"}, n, lo, hi);
        check({tag, "_codc_kept"}, int'(bus.dato_codc_o), codc);
        check({tag, "_codf_kept"}, int'(bus.dato_codf_o), codf);
        check({tag, "_resume"}, int'(bus.columnas_o), col_pat((codc + 1) % 4));
    endtask

    typedef struct packed {
        logic [15:0] keys;
        logic [15:0] extra;    // keys added while held, expected to be ignored
        logic [1:0]  codc;
        logic [1:0]  codf;
    } vec_t;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs[6];
        int   n;
        int   s0;
        bit   saw_low;

        vecs[0] = '{keys: 16'(1) << kbit(0,0), extra: 16'h0, codc: 2'd0, codf: 2'd0};
        vecs[1] = '{keys: 16'(1) << kbit(3,2), extra: 16'h0, codc: 2'd3, codf: 2'd2};
        vecs[2] = '{keys: (16'(1) << kbit(2,0)) | (16'(1) << kbit(2,2)),
                    extra: (16'(1) << kbit(1,0)) | (16'(1) << kbit(3,0)),
                    codc: 2'd2, codf: 2'd0};
        vecs[3] = '{keys: 16'(1) << kbit(1,3), extra: 16'(1) << kbit(0,3), codc: 2'd1, codf: 2'd3};
        vecs[4] = '{keys: 16'(1) << kbit(3,3), extra: 16'h0, codc: 2'd3, codf: 2'd3};
        vecs[5] = '{keys: (16'(1) << kbit(0,1)) | (16'(1) << kbit(0,3)),
                    extra: 16'(1) << kbit(2,1), codc: 2'd0, codf: 2'd1};

        // 1. Reset held with key "5" pressed; first column advance 4 cycles after release.
        rst  = 1'b0;
        keys = 16'(1) << kbit(1,1);
        repeat (3) @(negedge clk);
        check_reset("rst_init");
        rst = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("rst_adv_%0d", i), int'(bus.columnas_o),
                  (i < 4) ? 4'b1110 : 4'b1101);
        end

        // 2. Key "5" was pressed throughout, so latency counts from reset release.
        wait_listo(1'b0, LAT_MAX, n);
        check_range("k5_press_lat", (n < 0) ? -1 : n + 4, LAT_MIN, LAT_MAX);
        check("k5_codc", int'(bus.dato_codc_o), 1);
        check("k5_codf", int'(bus.dato_codf_o), 1);
        repeat (6) @(negedge clk);
        check("k5_cols_held", int'(bus.columnas_o), 4'b1101);
        check("k5_listo_held", int'(bus.dato_listo_o), 0);
        release_expect("k5", 1, 1, REL_LAT, REL_LAT);
        repeat (5) @(negedge clk);

        // Table-driven presses, including two keys in one column and ignored extra keys.
        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            s0  = strobes;
            press_expect(tag, vecs[i].keys, vecs[i].codc, vecs[i].codf, LAT_MIN, LAT_MAX);
            if (vecs[i].extra != 16'h0) begin
                keys = vecs[i].keys | vecs[i].extra;
                repeat (12) @(negedge clk);
                check({tag, "_extra_codc"}, int'(bus.dato_codc_o), int'(vecs[i].codc));
                check({tag, "_extra_codf"}, int'(bus.dato_codf_o), int'(vecs[i].codf));
                check({tag, "_extra_listo"}, int'(bus.dato_listo_o), 0);
            end else begin
                repeat (3) @(negedge clk);
            end
            release_expect(tag, vecs[i].codc, vecs[i].codf, REL_LAT, REL_LAT);
            check({tag, "_strobes"}, strobes - s0, 1);
            repeat (5) @(negedge clk);
        end

        // 3. Bouncing press on (2,3): 21 cycles of 3-cycle toggles, then a stable hold.
        s0      = strobes;
        saw_low = 1'b0;
        for (int ph = 0; ph < 7; ph++) begin
            keys = (ph % 2 == 1) ? (16'(1) << kbit(2,3)) : 16'h0;
            repeat (3) begin
                @(negedge clk);
                if (bus.dato_listo_o !== 1'b1) saw_low = 1'b1;
            end
        end
        check("bounce_no_strobe", int'(saw_low), 0);
        press_expect("bounce", 16'(1) << kbit(2,3), 2, 3, LAT_MIN, LAT_MAX);
        repeat (4) @(negedge clk);
        release_expect("bounce", 2, 3, REL_LAT, REL_LAT);
        check("bounce_strobes", strobes - s0, 1);
        repeat (5) @(negedge clk);

        // 4. Key "0" (col 1, row 3) released with two short glitches.
        s0 = strobes;
        press_expect("k0", 16'(1) << kbit(1,3), 1, 3, LAT_MIN, LAT_MAX);
        repeat (4) @(negedge clk);
        keys = '0;                      repeat (3) @(negedge clk);
        keys = 16'(1) << kbit(1,3);     repeat (2) @(negedge clk);
        keys = '0;                      repeat (3) @(negedge clk);
        keys = 16'(1) << kbit(1,3);     repeat (2) @(negedge clk);
        check("k0_listo_glitch", int'(bus.dato_listo_o), 0);
        release_expect("k0", 1, 3, DEB + 2, REL_LAT);
        check("k0_strobes", strobes - s0, 1);
        repeat (5) @(negedge clk);

        // Randomised presses checked against the keypad rules.
        for (int it = 0; it < 20; it++) begin
            int c, r, ec, er;
            string tag;
            tag = $sformatf("rnd%0d", it);
            c   = $urandom_range(0, 3);
            r   = $urandom_range(0, 3);
            s0  = strobes;
            press_expect(tag, 16'(1) << kbit(c, r), c, r, LAT_MIN, LAT_MAX);
            if ($urandom_range(0, 1) == 1) begin
                ec   = (c + 1 + $urandom_range(0, 2)) % 4;
                er   = $urandom_range(0, 3);
                keys = keys | (16'(1) << kbit(ec, er));
            end
            repeat ($urandom_range(1, 10)) @(negedge clk);
            check({tag, "_held_codc"}, int'(bus.dato_codc_o), c);
            release_expect(tag, c, r, REL_LAT, REL_LAT);
            check({tag, "_strobes"}, strobes - s0, 1);
            repeat ($urandom_range(0, 9)) @(negedge clk);
        end

        // 6a. Reset while held (SOSTENIDO); key stays down and must re-debounce.
        press_expect("sost", 16'(1) << kbit(2,1), 2, 1, LAT_MIN, LAT_MAX);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset("rst_sost");
        rst = 1'b1;
        s0  = strobes;
        wait_listo(1'b0, LAT_MAX + 5, n);
        check_range("sost_relat", n, LAT_MIN, LAT_MAX);
        check("sost_re_codc", int'(bus.dato_codc_o), 2);
        check("sost_re_codf", int'(bus.dato_codf_o), 1);
        release_expect("sost", 2, 1, REL_LAT, REL_LAT);
        check("sost_strobes", strobes - s0, 1);

        // 6b. Reset during the press debounce of (0,2); key released with reset.
        n = 0;
        while (bus.columnas_o === 4'b1110 && n < 20) begin @(negedge clk); n++; end
        while (bus.columnas_o !== 4'b1110 && n < 40) begin @(negedge clk); n++; end
        check("rebp_sync_col0", int'(bus.columnas_o), 4'b1110);
        keys = 16'(1) << kbit(0,2);
        repeat (7) @(negedge clk);
        check("rebp_frozen", int'(bus.columnas_o), 4'b1110);
        check("rebp_no_strobe_yet", int'(bus.dato_listo_o), 1);
        s0   = strobes;
        rst  = 1'b0;
        keys = '0;
        @(negedge clk);
        check_reset("rst_rebp");
        rst = 1'b1;
        repeat (40) @(negedge clk);
        check("rebp_no_spurious", strobes - s0, 0);
        check("rebp_listo_idle", int'(bus.dato_listo_o), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
